// File: rtl/demux_pkg.sv
// Shared widths and the select-to-bit index map used by the 1:32 demux and the matching 32:1 mux.
package demux_pkg;

    localparam int SEL_W  = 5;
    localparam int DATA_W = 32;

    // Mux-compatible map reverses the 8-bit group order: idx = (3 - s[4:3])*8 + s[2:0].
    function automatic logic [SEL_W-1:0] sel_to_idx(input logic [SEL_W-1:0] sel, input logic mux_map);
        logic [1:0] grp;
        grp = 2'd3 - sel[4:3];
        return mux_map ? {grp, sel[2:0]} : sel;
    endfunction

endpackage

// File: rtl/v1to32demux_reg_sel_map.sv
// Select -> one-hot write strobe: a 2:4 group decode feeding four 3:8 row decoders.
module _2to4decoder (
    input  logic [1:0] a,
    input  logic       en,
    output logic [3:0] y
);
    always_comb begin
        y = '0;
        if (en) y[a] = 1'b1;
    end
endmodule

module demux_sel_map
    import demux_pkg::*;
#(
    parameter bit MUX_MAP = 1'b1
) (
    input  logic [SEL_W-1:0]  sel,
    input  logic              en,
    output logic [DATA_W-1:0] strobe
);
    logic [3:0] grp;

    _2to4decoder u_grp (
        .a  (sel[4:3]),
        .en (en),
        .y  (grp)
    );

    for (genvar g = 0; g < 4; g++) begin : g_row
        // Row placement comes from the shared map so decode and reference cannot drift apart.
        localparam logic [SEL_W-1:0] BASE = sel_to_idx(SEL_W'(g * 8), MUX_MAP);
        logic [7:0] row;
        always_comb begin
            row = '0;
            if (grp[g]) row[sel[2:0]] = 1'b1;
        end
        assign strobe[BASE +: 8] = row;
    end
endmodule

// File: rtl/v1to32demux_reg.sv
// Registered 1:32 demultiplexer with auto pointer, frame-full handshake and sticky overrun flag.
module v1to32demux_reg
    import demux_pkg::*;
#(
    parameter bit MUX_MAP = 1'b1
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              DIN,
    input  logic [SEL_W-1:0]  DS,
    input  logic              DMODE,
    input  logic              DEN,
    output logic              DRDY,
    input  logic              DACK,
    input  logic              DCLR,
    output logic [DATA_W-1:0] DOUT,
    output logic              DFULL,
    output logic [SEL_W-1:0]  DPTR,
    output logic              DERR
);
    // Write handshake: a bit is taken on an edge where DEN & DRDY are both high and DCLR is low;
    // DRDY depends only on registered frame state, never on DEN.
    logic [DATA_W-1:0] dout_q, mask_q, strobe, mask_next;
    logic [SEL_W-1:0]  dptr_q, sel;
    logic              dfull_q, derr_q, accept;

    assign DRDY   = ~dfull_q;
    assign accept = DEN & DRDY & ~DCLR;
    assign sel    = DMODE ? dptr_q : DS;

    demux_sel_map #(.MUX_MAP(MUX_MAP)) u_sel_map (
        .sel    (sel),
        .en     (accept),
        .strobe (strobe)
    );

    assign mask_next = mask_q | strobe;

    always_ff @(posedge CLK) begin
        if (!RST_N || DCLR) begin
            dout_q  <= '0;
            mask_q  <= '0;
            dptr_q  <= '0;
            dfull_q <= 1'b0;
            derr_q  <= 1'b0;
        end else begin
            dout_q <= (dout_q & ~strobe) | (strobe & {DATA_W{DIN}});
            if (DEN && !DRDY) derr_q <= 1'b1;
            if (dfull_q && DACK) begin
                mask_q  <= '0;
                dptr_q  <= '0;
                dfull_q <= 1'b0;
            end else begin
                mask_q  <= mask_next;
                dfull_q <= &mask_next;
                if (accept && DMODE) dptr_q <= dptr_q + 5'd1;
            end
        end
    end

    assign DOUT  = dout_q;
    assign DFULL = dfull_q;
    assign DPTR  = dptr_q;
    assign DERR  = derr_q;
endmodule
